csa_tree_pipe: RTL and testbench

//  Parametrised, pipelined multi-operand carry-save reduction tree built from 3:2 CSA levels.
//  - Reduces NUM_OP operands of W bits to a redundant (sum, carry) pair, modulo 2^W.
//  - Has one register stage per CSA level and a valid/ready handshake.
//  - Optionally adds a final carry-propagate sum.
//  - Used as the partial-product compressor of the EXU Wallace multiplier and for multi-operand adds.

---
 rtl/csa_tree_pipe.sv | 172 +++++++++++++++++
 tb/tb_csa_tree_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand 3:2 carry-save reduction tree: NUM_OP W-bit operands -> redundant (o_s, o_c) pair, optional final add.
// Latency: LEVELS cycles (one register stage per CSA level); o_sum is combinational from the last stage.
// Backpressure: valid/ready; stages advance into empty or advancing successors, o_ready drops only when every stage is full and stalled.
//
// Ports: i_clk/i_rst_n (async active-low), i_flush (sync drop of all in-flight beats),
//        i_valid/o_ready/i_ops/i_tag input beat, o_valid/i_ready/o_s/o_c/o_sum/o_tag output beat.
module csa_tree_pipe #(
    parameter int W         = 64,
    parameter int NUM_OP    = 8,
    parameter int TAG_W     = 4,
    parameter int FINAL_ADD = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NUM_OP*W-1:0]   i_ops,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [W-1:0]          o_s,
    output logic [W-1:0]          o_c,
    output logic [W-1:0]          o_sum,
    output logic [TAG_W-1:0]      o_tag
);

    // Vector count after one 3:2 level: each triple yields two, leftovers pass through.
    function automatic int next_n(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Vector count entering level j.
    function automatic int n_at(input int j);
        int n;
        n = NUM_OP;
        for (int i = 0; i < j; i++) n = next_n(n);
        return n;
    endfunction

    function automatic int calc_levels();
        int n;
        int l;
        n = NUM_OP;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = next_n(n);
                l++;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels();

    logic [LEVELS-1:0] vld;     // stage holds a live beat
    logic [LEVELS-1:0] adv;     // stage hands its beat onward this cycle
    logic [LEVELS-1:0] load;    // stage captures a new beat this cycle
    logic [TAG_W-1:0]  tag_q [LEVELS];
    logic              accept;

    // Advance ripples backwards from the output so a full pipe still streams
    // one beat per cycle when the consumer is ready.
    always_comb begin
        adv = '0;
        adv[LEVELS-1] = vld[LEVELS-1] & i_ready;
        for (int k = LEVELS - 2; k >= 0; k--) begin
            adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
        end
    end

    assign o_ready = ~vld[0] | adv[0];
    assign accept  = i_valid & o_ready;

    always_comb begin
        load = '0;
        load[0] = accept;
        for (int k = 1; k < LEVELS; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Flush wins over both capture and drain; data registers are left as-is.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld <= '0;
        end else if (i_flush) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (load[k]) begin
                    vld[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LEVELS; k++) tag_q[k] <= '0;
        end else begin
            if (load[0]) tag_q[0] <= i_tag;
            for (int k = 1; k < LEVELS; k++) begin
                if (load[k]) tag_q[k] <= tag_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = n_at(k);
        localparam int NO = n_at(k + 1);
        localparam int NT = NI / 3;
        localparam int NR = NI % 3;

        logic [W-1:0] vin  [NI];
        logic [W-1:0] vout [NO];
        logic [W-1:0] dat  [NO];

        if (k == 0) begin : g_src
            for (genvar i = 0; i < NI; i++) begin : g_i
                assign vin[i] = i_ops[i*W +: W];
            end
        end else begin : g_src
            for (genvar i = 0; i < NI; i++) begin : g_i
                assign vin[i] = g_lvl[k-1].dat[i];
            end
        end

        // Full adder per bit: sum stays in place, carry moves up one bit
        // (MSB carry falls off, keeping everything modulo 2^W).
        for (genvar t = 0; t < NT; t++) begin : g_csa
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] c;
            logic [W-1:0] maj;
            assign a   = vin[3*t];
            assign b   = vin[3*t+1];
            assign c   = vin[3*t+2];
            assign maj = (a & b) | (c & (a ^ b));
            assign vout[2*t]   = a ^ b ^ c;
            assign vout[2*t+1] = {maj[W-2:0], 1'b0};
        end

        // Leftovers keep their relative order after the triple outputs.
        for (genvar r = 0; r < NR; r++) begin : g_pass
            assign vout[2*NT+r] = vin[3*NT+r];
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < NO; i++) dat[i] <= '0;
            end else if (load[k]) begin
                for (int i = 0; i < NO; i++) dat[i] <= vout[i];
            end
        end
    end

    assign o_valid = vld[LEVELS-1];
    assign o_tag   = tag_q[LEVELS-1];
    assign o_s     = g_lvl[LEVELS-1].dat[0];
    assign o_c     = g_lvl[LEVELS-1].dat[1];

    if (FINAL_ADD != 0) begin : g_fadd
        assign o_sum = o_s + o_c;
    end else begin : g_nofadd
        assign o_sum = '0;
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Testbench for csa_tree_pipe: random beats against a modular-sum model via a scoreboard queue,
// plus directed latency, wrap, backpressure, flush and async-reset scenarios.
// A second instance with NUM_OP=3 covers the single-level configuration.
module tb_csa_tree_pipe;
    localparam int W   = 64;
    localparam int NOP = 8;
    localparam int TW  = 4;
    localparam int LEV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [NOP*W-1:0]  i_ops;
    logic [TW-1:0]     i_tag;
    logic              o_valid;
    logic              i_ready;
    logic [W-1:0]      o_s;
    logic [W-1:0]      o_c;
    logic [W-1:0]      o_sum;
    logic [TW-1:0]     o_tag;

    csa_tree_pipe #(.W(W), .NUM_OP(NOP), .TAG_W(TW), .FINAL_ADD(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_ops(i_ops), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_s(o_s), .o_c(o_c), .o_sum(o_sum), .o_tag(o_tag)
    );

    logic              c3_valid;
    logic              c3_ready;
    logic [3*W-1:0]    c3_ops;
    logic [TW-1:0]     c3_tag;
    logic              c3_ovalid;
    logic [W-1:0]      c3_s;
    logic [W-1:0]      c3_c;
    logic [W-1:0]      c3_sum;
    logic [TW-1:0]     c3_otag;
    logic              c3_flush;
    logic              c3_iready;

    csa_tree_pipe #(.W(W), .NUM_OP(3), .TAG_W(TW), .FINAL_ADD(1)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(c3_flush), .i_valid(c3_valid), .o_ready(c3_ready),
        .i_ops(c3_ops), .i_tag(c3_tag), .o_valid(c3_ovalid), .i_ready(c3_iready),
        .o_s(c3_s), .o_c(c3_c), .o_sum(c3_sum), .o_tag(c3_otag)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  sum;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_out   = 0;
    int run     = 0;
    int max_run = 0;
    int stalls  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // Reference: the operands' plain sum modulo 2^W.
    function automatic logic [W-1:0] model_sum(input logic [NOP*W-1:0] ops);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < NOP; k++) s = s + ops[k*W +: W];
        return s;
    endfunction

    function automatic logic [NOP*W-1:0] rand_ops();
        logic [NOP*W-1:0] r;
        for (int k = 0; k < NOP; k++) r[k*W +: W] = {$urandom, $urandom};
        return r;
    endfunction

    // Monitor: every transferred output beat is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_out++;
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL out_unexpected: got beat with tag %0d, required no beat", o_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_tag", 64'(o_tag), 64'(mon_e.tag));
                chk("out_sum", o_sum, mon_e.sum);
                chk("out_s_plus_c", o_s + o_c, mon_e.sum);
            end
        end else begin
            run = 0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [NOP*W-1:0] ops, input logic [TW-1:0] tag);
        int   guard;
        exp_t e;
        guard   = 0;
        i_valid = 1'b1;
        i_ops   = ops;
        i_tag   = tag;
        forever begin
            @(negedge clk);
            if (o_ready) begin
                e.tag = tag;
                e.sum = model_sum(ops);
                exp_q.push_back(e);
                break;
            end
            stalls++;
            guard++;
            if (guard > 100) begin
                n_chk++;
                $display("FAIL issue_timeout: tag %0d not accepted after 100 cycles, required acceptance", tag);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Counts edges from acceptance until o_valid; returns at the negedge where it is seen.
    task automatic wait_out(output int edges);
        edges = 1;
        forever begin
            @(negedge clk);
            if (o_valid) break;
            if (edges > 50) begin
                n_chk++;
                $display("FAIL wait_out_timeout: o_valid not seen in 50 cycles, required 1");
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        int               cnt;
        int               n0;
        logic             stable;
        logic [W-1:0]     hs, hc, hsum;
        logic [TW-1:0]    htag;
        logic             hv;
        logic [NOP*W-1:0] ops;

        rst_n     = 1'b0;
        i_flush   = 1'b0;
        i_valid   = 1'b0;
        i_ops     = '0;
        i_tag     = '0;
        i_ready   = 1'b1;
        c3_valid  = 1'b0;
        c3_ops    = '0;
        c3_tag    = '0;
        c3_flush  = 1'b0;
        c3_iready = 1'b1;

        // Reset state
        #12;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_s", o_s, 64'd0);
        chk("rst_o_c", o_c, 64'd0);
        chk("rst_o_sum", o_sum, 64'd0);
        chk("rst_o_tag", 64'(o_tag), 64'd0);
        chk("rst_c3_valid", 64'(c3_ovalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;

        // NUM_OP=3: single level, one-cycle latency
        c3_valid = 1'b1;
        c3_ops   = {64'd1, 64'd3, 64'd5};
        c3_tag   = 4'd3;
        @(negedge clk);
        chk("c3_ready", 64'(c3_ready), 64'd1);
        chk("c3_not_early", 64'(c3_ovalid), 64'd0);
        @(posedge clk);
        #1;
        c3_valid = 1'b0;
        @(negedge clk);
        chk("c3_valid", 64'(c3_ovalid), 64'd1);
        chk("c3_s", c3_s, 64'd7);
        chk("c3_c", c3_c, 64'd2);
        chk("c3_sum", c3_sum, 64'd9);
        chk("c3_tag", 64'(c3_otag), 64'd3);
        @(posedge clk);
        #1;

        // Operands 1..8: latency LEVELS, sum 36
        for (int k = 0; k < NOP; k++) ops[k*W +: W] = 64'(k + 1);
        issue(ops, 4'd5);
        wait_out(lat);
        chk("lat_1to8", 64'(lat), 64'(LEV));
        chk("sum_1to8", o_sum, 64'd36);
        @(posedge clk);
        #1;
        drain("drain_1to8");

        // All-ones operands wrap to -8
        ops = '1;
        issue(ops, 4'd6);
        wait_out(lat);
        chk("wrap_sum", o_sum, 64'hFFFF_FFFF_FFFF_FFF8);
        @(posedge clk);
        #1;
        drain("drain_wrap");

        // Back-to-back stream: 10 beats, no stalls, 10 consecutive outputs
        stalls  = 0;
        max_run = 0;
        for (int i = 0; i < 10; i++) issue(rand_ops(), 4'(i));
        chk("b2b_no_stall", 64'(stalls), 64'd0);
        drain("drain_b2b");
        chk("b2b_run", 64'(max_run), 64'd10);

        // Backpressure: fill all stages, output holds, then drain in order
        i_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_ops   = rand_ops();
            i_tag   = 4'(i);
            @(negedge clk);
            if (!o_ready) break;
            begin
                exp_t e;
                e.tag = i_tag;
                e.sum = model_sum(i_ops);
                exp_q.push_back(e);
            end
            cnt++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(cnt), 64'(LEV));
        hv = o_valid; hs = o_s; hc = o_c; hsum = o_sum; htag = o_tag;
        chk("bp_o_valid", 64'(hv), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_valid !== hv || o_s !== hs || o_c !== hc || o_sum !== hsum ||
                o_tag !== htag || o_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_hold_stable", 64'(stable), 64'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        issue(i_ops, i_tag);
        drain("drain_bp");

        // Flush with 3 beats in flight and a beat offered in the flush cycle
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(rand_ops(), 4'(10 + i));
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_ops   = rand_ops();
        i_tag   = 4'd15;
        @(negedge clk);
        exp_q.delete();
        n0 = n_out;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("flush_o_valid", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_no_out", 64'(n_out - n0), 64'd0);
        issue(rand_ops(), 4'd7);
        wait_out(lat);
        chk("post_flush_lat", 64'(lat), 64'(LEV));
        @(posedge clk);
        #1;
        drain("drain_flush");

        // Async reset mid-stream clears o_valid without a clock edge
        i_ready = 1'b0;
        issue(rand_ops(), 4'd1);
        issue(rand_ops(), 4'd2);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_o_valid", 64'(o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_o_valid", 64'(o_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(rand_ops(), 4'd9);
        drain("drain_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
